// File: rtl/spi_frame_pkg.sv
// Shared definitions for the SPI target datagram.
// Frame layout (MSB first on the wire): [39] write flag, [38:32] register
// address, [31:0] register data. The response frame is {status[7:0], rdata[31:0]}.
// Also holds the FSM state encoding used by spi_target.
package spi_frame_pkg;
  localparam int STATUS_WIDTH = 8;

  localparam int WRITE_BIT = 39;
  localparam int ADDR_MSB  = 38;
  localparam int ADDR_LSB  = 32;
  localparam int DATA_MSB  = 31;
  localparam int DATA_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/spi_target_sync_edge.sv
// sync_edge: 2-FF synchronizer for an asynchronous input, followed by a
// rise/fall detector on the synchronized level.
// Ports:
//   clk_in    - system clock
//   rst_n_in  - asynchronous active-low reset (all flops load RST_VAL)
//   d_in      - asynchronous input
//   rise_out  - one-cycle pulse on a synchronized 0->1 transition
//   fall_out  - one-cycle pulse on a synchronized 1->0 transition
// RST_VAL should be the idle level of the input so that leaving reset does
// not fabricate an edge.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic d_in,
  output logic rise_out,
  output logic fall_out
);
  logic meta_q, sync_q, prev_q;
  logic meta_d, sync_d, prev_d;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_out =  sync_q & ~prev_q;
  assign fall_out = ~sync_q &  prev_q;
endmodule

// File: rtl/spi_target.sv
// spi_target: SPI mode-3 target for the 40-bit {rw, addr, data} datagram.
// A committed frame raises rd_strobe_out (and wr_strobe_out for writes) for
// one cycle; the read data captured the cycle after the strobe is returned,
// together with the status byte sampled at frame start, on the next frame.
// Ports:
//   clk_in, reset_n_in          - system clock, async active-low reset
//   sck_in, cs_n_in, serial_in  - SPI clock (idles high), chip select, MOSI
//   serial_out, serial_out_en   - MISO data and drive enable
//   status_in, rd_data_in       - response status byte and register read data
//   reg_addr_out, reg_wdata_out - address / write data of last committed frame
//   wr_strobe_out, rd_strobe_out- one-cycle commit pulses
//   r_busy_out                  - frame in progress
//   err_clr_in, err_count_out   - only with SPI_TARGET_ERRCNT_EN defined:
//                                 saturating count of aborted/overrun frames
module spi_target
  import spi_frame_pkg::*;
#(
  parameter int SIZE       = 40,
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_in,
  input  logic                    reset_n_in,
  input  logic                    sck_in,
  input  logic                    cs_n_in,
  input  logic                    serial_in,
  output logic                    serial_out,
  output logic                    serial_out_en,
  input  logic [STATUS_WIDTH-1:0] status_in,
  input  logic [DATA_WIDTH-1:0]   rd_data_in,
`ifdef SPI_TARGET_ERRCNT_EN
  input  logic                    err_clr_in,
  output logic [15:0]             err_count_out,
`endif
  output logic [ADDR_WIDTH-1:0]   reg_addr_out,
  output logic [DATA_WIDTH-1:0]   reg_wdata_out,
  output logic                    wr_strobe_out,
  output logic                    rd_strobe_out,
  output logic                    r_busy_out
);
  // bit_cnt saturates at SIZE+1 so an overrun stays distinguishable from SIZE
  localparam int                CNT_W    = $clog2(SIZE + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(SIZE);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(SIZE + 1);

  logic sck_rise, sck_fall, cs_rise, cs_fall;

  sync_edge #(.RST_VAL(1'b1)) u_sck_sync (
    .clk_in(clk_in), .rst_n_in(reset_n_in), .d_in(sck_in),
    .rise_out(sck_rise), .fall_out(sck_fall)
  );

  sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk_in(clk_in), .rst_n_in(reset_n_in), .d_in(cs_n_in),
    .rise_out(cs_rise), .fall_out(cs_fall)
  );

  // MOSI takes the same 2-FF latency as SCK so it lines up with sck_rise
  logic sin_meta_q, sin_sync_q, sin_meta_d, sin_sync_d;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [SIZE-1:0]         rx_q, rx_d;
  logic [SIZE-1:0]         tx_q, tx_d;
  logic                    so_q, so_d;
  logic                    so_en_q, so_en_d;
  logic                    busy_q, busy_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    wr_stb_q, wr_stb_d;
  logic                    rd_stb_q, rd_stb_d;
  logic [DATA_WIDTH-1:0]   rbuf_q, rbuf_d;
  logic                    ld_buf_q, ld_buf_d;   // post-commit cycle
  logic                    pend_q, pend_d;       // CS fell while not startable

  always_comb begin
    sin_meta_d = serial_in;
    sin_sync_d = sin_meta_q;

    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    so_d      = so_q;
    so_en_d   = so_en_q;
    busy_d    = busy_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_stb_d  = 1'b0;
    rd_stb_d  = 1'b0;
    rbuf_d    = rbuf_q;
    ld_buf_d  = 1'b0;
    pend_d    = pend_q;

    // Write frames refresh the buffer too, so the next frame always returns
    // data for the most recently committed address.
    if (ld_buf_q) rbuf_d = rd_data_in;

    case (state_q)
      IDLE: begin
        if (cs_rise) pend_d = 1'b0;
        // Not startable in the post-commit cycle: rbuf_q is still stale.
        if ((cs_fall || pend_q) && !cs_rise && !ld_buf_q) begin
          state_d   = SHIFT;
          tx_d      = {status_in, rbuf_q};
          so_d      = status_in[STATUS_WIDTH-1];
          so_en_d   = 1'b1;
          busy_d    = 1'b1;
          bit_cnt_d = '0;
          pend_d    = 1'b0;
        end else if (cs_fall) begin
          pend_d = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = DONE;
          so_en_d = 1'b0;
          so_d    = 1'b0;
          busy_d  = 1'b0;
        end else begin
          if (sck_rise) begin
            rx_d = {rx_q[SIZE-2:0], sin_sync_q};
            if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + 1'b1;
          end
          // Mode 3: the first falling edge precedes any sample and must keep
          // the MSB on the line; later falls advance to the next bit.
          if (sck_fall && bit_cnt_q != '0) begin
            tx_d = {tx_q[SIZE-2:0], 1'b0};
            so_d = tx_q[SIZE-2];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (cs_fall) pend_d = 1'b1;
        if (bit_cnt_q == CNT_FULL) begin
          addr_d   = rx_q[ADDR_MSB:ADDR_LSB];
          rd_stb_d = 1'b1;
          ld_buf_d = 1'b1;
          if (rx_q[WRITE_BIT]) begin
            wdata_d  = rx_q[DATA_MSB:DATA_LSB];
            wr_stb_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      sin_meta_q <= 1'b0;
      sin_sync_q <= 1'b0;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      so_q       <= 1'b0;
      so_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_stb_q   <= 1'b0;
      rd_stb_q   <= 1'b0;
      rbuf_q     <= '0;
      ld_buf_q   <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      sin_meta_q <= sin_meta_d;
      sin_sync_q <= sin_sync_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      so_q       <= so_d;
      so_en_q    <= so_en_d;
      busy_q     <= busy_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_stb_q   <= wr_stb_d;
      rd_stb_q   <= rd_stb_d;
      rbuf_q     <= rbuf_d;
      ld_buf_q   <= ld_buf_d;
      pend_q     <= pend_d;
    end
  end

  assign serial_out    = so_q;
  assign serial_out_en = so_en_q;
  assign r_busy_out    = busy_q;
  assign reg_addr_out  = addr_q;
  assign reg_wdata_out = wdata_q;
  assign wr_strobe_out = wr_stb_q;
  assign rd_strobe_out = rd_stb_q;

`ifdef SPI_TARGET_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr_in)
      err_cnt_d = '0;
    else if (state_q == DONE && bit_cnt_q != CNT_FULL && err_cnt_q != 16'hFFFF)
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) err_cnt_q <= '0;
    else             err_cnt_q <= err_cnt_d;
  end

  assign err_count_out = err_cnt_q;
`endif
endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a mode-3 SPI master drives frames, a
// scoreboard queue holds the commits each full frame should produce and a
// monitor pops them on every strobe. MISO of each frame is compared against
// {status, last committed read data} tracked by the bench.
module tb_spi_target;
  localparam int HALF = 8;  // SCK half period in clk_in cycles

  logic        clk_in = 1'b0;
  logic        reset_n_in;
  logic        sck_in, cs_n_in, serial_in;
  logic        serial_out, serial_out_en;
  logic [7:0]  status_in;
  logic [31:0] rd_data_in;
  logic [6:0]  reg_addr_out;
  logic [31:0] reg_wdata_out;
  logic        wr_strobe_out, rd_strobe_out, r_busy_out;
`ifdef SPI_TARGET_ERRCNT_EN
  logic        err_clr_in;
  logic [15:0] err_count_out;
`endif

  always #20 clk_in = ~clk_in;

  spi_target dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in),
    .sck_in(sck_in), .cs_n_in(cs_n_in), .serial_in(serial_in),
    .serial_out(serial_out), .serial_out_en(serial_out_en),
    .status_in(status_in), .rd_data_in(rd_data_in),
`ifdef SPI_TARGET_ERRCNT_EN
    .err_clr_in(err_clr_in), .err_count_out(err_count_out),
`endif
    .reg_addr_out(reg_addr_out), .reg_wdata_out(reg_wdata_out),
    .wr_strobe_out(wr_strobe_out), .rd_strobe_out(rd_strobe_out),
    .r_busy_out(r_busy_out)
  );

  typedef struct {
    logic        wr;
    logic [6:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          errors = 0, checks = 0;
  int          strobes_seen = 0, exp_commits = 0;
  logic [31:0] model_buf = '0;
  logic [6:0]  model_addr = '0;
  logic [31:0] model_wdata = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every strobe cycle must match the oldest expected commit.
  always @(negedge clk_in) begin
    if (rd_strobe_out === 1'b1 || wr_strobe_out === 1'b1) begin
      strobes_seen++;
      if (exp_q.size() == 0) begin
        chk("spurious_strobe", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rd_strobe", {63'd0, rd_strobe_out}, 64'd1);
        chk("wr_strobe", {63'd0, wr_strobe_out}, {63'd0, mon_e.wr});
        chk("reg_addr", {57'd0, reg_addr_out}, {57'd0, mon_e.addr});
        if (mon_e.wr) chk("reg_wdata", {32'd0, reg_wdata_out}, {32'd0, mon_e.data});
      end
    end
  end

  task automatic spi_xfer(input logic [39:0] mosi, input int nbits, input logic [7:0] status);
    logic [47:0] got;
    logic [79:0] exp_full;
    logic [47:0] exp_bits;
    int          lat;
    status_in = status;
    exp_full  = {status, model_buf, 40'd0};  // zeros once the response is exhausted
    got       = '0;
    @(negedge clk_in);
    cs_n_in = 1'b0;
    repeat (HALF) @(negedge clk_in);
    for (int i = 0; i < nbits; i++) begin
      sck_in    = 1'b0;
      serial_in = (i < 40) ? mosi[39-i] : 1'b0;
      repeat (HALF) @(negedge clk_in);
      if (i == 0) begin
        chk("busy_in_frame", {63'd0, r_busy_out}, 64'd1);
        chk("oe_in_frame", {63'd0, serial_out_en}, 64'd1);
      end
      got    = {got[46:0], serial_out};
      sck_in = 1'b1;
      repeat (HALF) @(negedge clk_in);
    end
    exp_bits = 48'(exp_full >> (80 - nbits));
    chk("miso", {16'd0, got}, {16'd0, exp_bits});
    if (nbits == 40) begin
      exp_q.push_back('{wr: mosi[39], addr: mosi[38:32], data: mosi[31:0]});
      exp_commits++;
      model_addr = mosi[38:32];
      if (mosi[39]) model_wdata = mosi[31:0];
    end
    cs_n_in = 1'b1;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_in);
      if (lat == 0 && rd_strobe_out === 1'b1) lat = k;
    end
    if (nbits == 40) begin
      chk("strobe_latency", 64'(lat), 64'd4);
      model_buf = rd_data_in;
    end
    chk("strobe_count", 64'(strobes_seen), 64'(exp_commits));
    chk("reg_addr_hold", {57'd0, reg_addr_out}, {57'd0, model_addr});
    chk("reg_wdata_hold", {32'd0, reg_wdata_out}, {32'd0, model_wdata});
    chk("busy_idle", {63'd0, r_busy_out}, 64'd0);
    chk("oe_idle", {63'd0, serial_out_en}, 64'd0);
  endtask

  initial begin
    reset_n_in = 1'b0;
    sck_in     = 1'b1;
    cs_n_in    = 1'b1;
    serial_in  = 1'b0;
    status_in  = 8'h00;
    rd_data_in = 32'hCAFEF00D;
`ifdef SPI_TARGET_ERRCNT_EN
    err_clr_in = 1'b0;
`endif
    repeat (5) @(negedge clk_in);
    chk("rst_oe", {63'd0, serial_out_en}, 64'd0);
    chk("rst_wr", {63'd0, wr_strobe_out}, 64'd0);
    chk("rst_rd", {63'd0, rd_strobe_out}, 64'd0);
    chk("rst_addr", {57'd0, reg_addr_out}, 64'd0);
    chk("rst_wdata", {32'd0, reg_wdata_out}, 64'd0);
    chk("rst_busy", {63'd0, r_busy_out}, 64'd0);
    reset_n_in = 1'b1;
    repeat (5) @(negedge clk_in);

    spi_xfer(40'h80_DEADBEEF, 40, 8'h3C);
    rd_data_in = 32'h12345678;
    spi_xfer(40'h05_00000000, 40, 8'h11);
    rd_data_in = 32'h0BADBEEF;
    spi_xfer(40'h7F_00000000, 40, 8'hA5);   // returns A5_12345678
    rd_data_in = 32'h55AA33CC;
    spi_xfer(40'h93_11223344, 40, 8'h5A);

    spi_xfer(40'h81_55555555, 20, 8'hC3);   // abort
`ifdef SPI_TARGET_ERRCNT_EN
    chk("err_after_abort", {48'd0, err_count_out}, 64'd1);
`endif
    spi_xfer(40'h82_66666666, 41, 8'h96);   // overrun
`ifdef SPI_TARGET_ERRCNT_EN
    chk("err_after_overrun", {48'd0, err_count_out}, 64'd2);
    @(negedge clk_in); err_clr_in = 1'b1;
    @(negedge clk_in); err_clr_in = 1'b0;
    chk("err_cleared", {48'd0, err_count_out}, 64'd0);
`endif
    rd_data_in = 32'h01020304;
    spi_xfer(40'h0A_FFFFFFFF, 40, 8'h0F);   // buffer untouched by bad frames

    // Reset in the middle of a frame.
    @(negedge clk_in);
    cs_n_in = 1'b0;
    repeat (HALF) @(negedge clk_in);
    for (int i = 0; i < 10; i++) begin
      sck_in = 1'b0; serial_in = i[0];
      repeat (HALF) @(negedge clk_in);
      sck_in = 1'b1;
      repeat (HALF) @(negedge clk_in);
    end
    reset_n_in = 1'b0;
    #1;
    chk("midrst_oe", {63'd0, serial_out_en}, 64'd0);
    chk("midrst_busy", {63'd0, r_busy_out}, 64'd0);
    chk("midrst_addr", {57'd0, reg_addr_out}, 64'd0);
    cs_n_in = 1'b1;
    repeat (4) @(negedge clk_in);
    reset_n_in = 1'b1;
    model_buf = '0; model_addr = '0; model_wdata = '0;
    repeat (4) @(negedge clk_in);
    rd_data_in = 32'hFEEDFACE;
    spi_xfer(40'hC2_A5A5A5A5, 40, 8'h77);
    spi_xfer(40'h42_00000000, 40, 8'h88);   // returns 88_FEEDFACE

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
